// File: rtl/udma_hyper_pkg.sv
// udma_hyper_pkg: shared scheduler state encoding and id-width helper
//   sched_state_e : IDLE -> ISSUE -> WAIT_DONE -> (RECOVERY) -> IDLE
//   id_width()    : channel id width, never narrower than one bit
package udma_hyper_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RECOVERY} sched_state_e;

    function automatic int id_width(input int nb_ch);
        return (nb_ch > 1) ? $clog2(nb_ch) : 1;
    endfunction

endpackage

// File: rtl/udma_hyper_ch_sched_if.sv
// udma_hyper_ch_sched_if: request, descriptor and completion bundle of the channel scheduler
//   master : scheduler side (takes channel requests, drives descriptor, busy vector, idle)
//   slave  : environment side (channels, transaction engine, config block)
interface udma_hyper_ch_sched_if #(
    parameter int NB_CH      = 8,
    parameter int TRANS_SIZE = 16,
    parameter int ADDR_W     = 32
);
    localparam int ID_W = udma_hyper_pkg::id_width(NB_CH);

    logic [31:0]                cfg_t_read_write_recovery_i;
    logic [NB_CH-1:0]           req_valid_i;
    logic [NB_CH-1:0]           req_ready_o;
    logic [NB_CH*ADDR_W-1:0]    req_addr_i;
    logic [NB_CH*TRANS_SIZE-1:0] req_size_i;
    logic [NB_CH-1:0]           req_rwn_i;
    logic                       trans_valid_o;
    logic                       trans_ready_i;
    logic [ADDR_W-1:0]          trans_addr_o;
    logic [TRANS_SIZE-1:0]      trans_size_o;
    logic                       trans_rwn_o;
    logic [ID_W-1:0]            trans_id_o;
    logic                       done_valid_i;
    logic [ID_W-1:0]            done_id_i;
    logic [NB_CH-1:0]           busy_vec_o;
    logic                       idle_o;

    modport master (
        input  cfg_t_read_write_recovery_i, req_valid_i, req_addr_i, req_size_i, req_rwn_i,
               trans_ready_i, done_valid_i, done_id_i,
        output req_ready_o, trans_valid_o, trans_addr_o, trans_size_o, trans_rwn_o, trans_id_o,
               busy_vec_o, idle_o
    );

    modport slave (
        output cfg_t_read_write_recovery_i, req_valid_i, req_addr_i, req_size_i, req_rwn_i,
               trans_ready_i, done_valid_i, done_id_i,
        input  req_ready_o, trans_valid_o, trans_addr_o, trans_size_o, trans_rwn_o, trans_id_o,
               busy_vec_o, idle_o
    );

endinterface

// File: rtl/udma_hyper_rr_arb.sv
// udma_hyper_rr_arb: combinational round-robin pick of the first eligible channel at or above rr_ptr_i
//   eligible_i   : channels allowed to win
//   rr_ptr_i     : highest-priority channel this cycle
//   gnt_onehot_o : winner as one-hot (zero when nothing eligible)
//   gnt_idx_o    : winner index
//   gnt_valid_o  : some channel won
module udma_hyper_rr_arb
    import udma_hyper_pkg::*;
#(
    parameter int NB_CH = 8,
    parameter int ID_W  = id_width(NB_CH)
) (
    input  logic [NB_CH-1:0] eligible_i,
    input  logic [ID_W-1:0]  rr_ptr_i,
    output logic [NB_CH-1:0] gnt_onehot_o,
    output logic [ID_W-1:0]  gnt_idx_o,
    output logic             gnt_valid_o
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the nearest eligible channel is written last and wins.
    always_comb begin
        idx         = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        for (int i = NB_CH - 1; i >= 0; i--) begin
            idx = ID_W'((int'(rr_ptr_i) + i) % NB_CH);
            if (eligible_i[idx]) begin
                gnt_idx_o   = idx;
                gnt_valid_o = 1'b1;
            end
        end
    end

    assign gnt_onehot_o = gnt_valid_o ? (NB_CH'(1) << gnt_idx_o) : '0;

endmodule

// File: rtl/udma_hyper_ch_sched.sv
// udma_hyper_ch_sched: round-robin scheduler of uDMA channel requests onto one HyperBus transaction engine
//   clk_i / rst_i : clock, synchronous active-high reset
//   bus (master)  : channel requests in, descriptor out, completion in, busy vector and idle out
module udma_hyper_ch_sched
    import udma_hyper_pkg::*;
#(
    parameter int NB_CH      = 8,
    parameter int TRANS_SIZE = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    udma_hyper_ch_sched_if.master  bus
);

    localparam int ID_W = id_width(NB_CH);

    sched_state_e          state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d, id_q, id_d, gnt_idx;
    logic [NB_CH-1:0]      busy_q, busy_d, eligible, gnt_onehot, req_ready;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [TRANS_SIZE-1:0] size_q, size_d;
    logic                  rwn_q, rwn_d, gnt_valid, trans_valid;
    logic [31:0]           rec_cnt_q, rec_cnt_d;

    assign eligible = bus.req_valid_i & ~busy_q;

    udma_hyper_rr_arb #(.NB_CH(NB_CH)) u_arb (
        .eligible_i   (eligible),
        .rr_ptr_i     (rr_ptr_q),
        .gnt_onehot_o (gnt_onehot),
        .gnt_idx_o    (gnt_idx),
        .gnt_valid_o  (gnt_valid)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        busy_d      = busy_q;
        addr_d      = addr_q;
        size_d      = size_q;
        rwn_d       = rwn_q;
        rec_cnt_d   = rec_cnt_q;
        req_ready   = '0;
        trans_valid = 1'b0;
        case (state_q)
            IDLE: if (gnt_valid) begin
                req_ready = gnt_onehot;
                addr_d    = bus.req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
                size_d    = bus.req_size_i[int'(gnt_idx)*TRANS_SIZE +: TRANS_SIZE];
                rwn_d     = bus.req_rwn_i[gnt_idx];
                id_d      = gnt_idx;
                busy_d    = busy_q | gnt_onehot;
                rr_ptr_d  = (gnt_idx == ID_W'(NB_CH - 1)) ? '0 : ID_W'(int'(gnt_idx) + 1);
                state_d   = ISSUE;
            end
            ISSUE: begin
                trans_valid = 1'b1;
                state_d     = bus.trans_ready_i ? WAIT_DONE : ISSUE;
            end
            // Completions for any other id are stale or foreign and must not free a channel.
            WAIT_DONE: if (bus.done_valid_i && bus.done_id_i == id_q) begin
                busy_d    = busy_q & ~(NB_CH'(1) << id_q);
                rec_cnt_d = bus.cfg_t_read_write_recovery_i;
                state_d   = (bus.cfg_t_read_write_recovery_i == '0) ? IDLE : RECOVERY;
            end
            // Leaving on rec_cnt==1 makes the number of RECOVERY cycles equal the programmed gap.
            RECOVERY: begin
                rec_cnt_d = rec_cnt_q - 32'd1;
                state_d   = (rec_cnt_q <= 32'd1) ? IDLE : RECOVERY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            busy_q    <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            rwn_q     <= 1'b0;
            rec_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            rwn_q     <= rwn_d;
            rec_cnt_q <= rec_cnt_d;
        end
    end

    assign bus.req_ready_o   = req_ready;
    assign bus.trans_valid_o = trans_valid;
    assign bus.trans_addr_o  = addr_q;
    assign bus.trans_size_o  = size_q;
    assign bus.trans_rwn_o   = rwn_q;
    assign bus.trans_id_o    = id_q;
    assign bus.busy_vec_o    = busy_q;
    assign bus.idle_o        = (state_q == IDLE);

endmodule

// File: tb/tb_udma_hyper_ch_sched.sv
// tb_udma_hyper_ch_sched: scoreboard bench for the channel scheduler with four channels
module tb_udma_hyper_ch_sched;

    localparam int NB_CH      = 4;
    localparam int TRANS_SIZE = 16;
    localparam int ADDR_W     = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]     addr;
        logic [TRANS_SIZE-1:0] size;
        logic                  rwn;
        logic [1:0]            id;
    } desc_t;

    logic  clk_i = 1'b0;
    logic  rst_i = 1'b1;
    int    checks = 0;
    int    errors = 0;
    desc_t exp_q[$];
    desc_t e;

    udma_hyper_ch_sched_if #(.NB_CH(NB_CH), .TRANS_SIZE(TRANS_SIZE), .ADDR_W(ADDR_W)) bus ();

    udma_hyper_ch_sched #(.NB_CH(NB_CH), .TRANS_SIZE(TRANS_SIZE), .ADDR_W(ADDR_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic desc_t mk(input logic [31:0] a, input logic [15:0] s, input logic r, input int id);
        return {a, s, r, 2'(id)};
    endfunction

    function automatic desc_t cur();
        return {bus.trans_addr_o, bus.trans_size_o, bus.trans_rwn_o, bus.trans_id_o};
    endfunction

    task automatic drive_req(input int ch, input logic [31:0] a, input logic [15:0] s, input logic r);
        bus.req_addr_i[ch*ADDR_W +: ADDR_W]         = a;
        bus.req_size_i[ch*TRANS_SIZE +: TRANS_SIZE] = s;
        bus.req_rwn_i[ch]                           = r;
        bus.req_valid_i[ch]                         = 1'b1;
    endtask

    task automatic clear_inputs();
        bus.cfg_t_read_write_recovery_i = '0;
        bus.req_valid_i   = '0;
        bus.req_addr_i    = '0;
        bus.req_size_i    = '0;
        bus.req_rwn_i     = '0;
        bus.trans_ready_i = 1'b0;
        bus.done_valid_i  = 1'b0;
        bus.done_id_i     = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_inputs();
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_inputs();
        @(negedge clk_i);
        #1;
        checks++;
        if (bus.idle_o !== 1'b1 || bus.busy_vec_o !== 4'b0 || bus.trans_valid_o !== 1'b0 || bus.req_ready_o !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: idle=%b busy=%b tvalid=%b ready=%b, want 1 0000 0 0000",
                     bus.idle_o, bus.busy_vec_o, bus.trans_valid_o, bus.req_ready_o);
        end
        checks++;
        if (cur() !== desc_t'(0)) begin
            errors++;
            $display("FAIL reset_desc: got %h want 0", cur());
        end
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk_i);
        drive_req(2, 32'h1000, 16'd64, 1'b1);
        exp_q.push_back(mk(32'h1000, 16'd64, 1'b1, 2));
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b want 0100", bus.req_ready_o);
        end
        @(negedge clk_i);
        bus.req_valid_i = '0;
        #1;
        checks++;
        if (!bus.trans_valid_o || bus.req_ready_o !== 4'b0) begin
            errors++;
            $display("FAIL single_issue: tvalid=%b ready=%b want 1 0000", bus.trans_valid_o, bus.req_ready_o);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (cur() !== e) begin
                errors++;
                $display("FAIL single_desc: got %h want %h", cur(), e);
            end
        end
        checks++;
        if (bus.busy_vec_o !== 4'b0100) begin
            errors++;
            $display("FAIL single_busy: got %b want 0100", bus.busy_vec_o);
        end
        bus.trans_ready_i = 1'b1;
        @(negedge clk_i);
        bus.trans_ready_i = 1'b0;
        bus.done_valid_i  = 1'b1;
        bus.done_id_i     = 2'd2;
        #1;
        checks++;
        if (bus.trans_valid_o !== 1'b0 || bus.idle_o !== 1'b0) begin
            errors++;
            $display("FAIL single_wait: tvalid=%b idle=%b want 0 0", bus.trans_valid_o, bus.idle_o);
        end
        @(negedge clk_i);
        bus.done_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.busy_vec_o !== 4'b0 || bus.idle_o !== 1'b1) begin
            errors++;
            $display("FAIL single_done: busy=%b idle=%b want 0000 1", bus.busy_vec_o, bus.idle_o);
        end
    endtask

    task automatic test_round_robin();
        int n_grant = 0;
        int n_done  = 0;
        int dcnt    = 0;
        int did     = 0;
        do_reset();
        @(negedge clk_i);
        for (int k = 0; k < NB_CH; k++)
            drive_req(k, 32'h2000 + k * 32'h100, 16'(8 * (k + 1)), k[0]);
        for (int k = 0; k < 5; k++)
            exp_q.push_back(mk(32'h2000 + (k % 4) * 32'h100, 16'(8 * ((k % 4) + 1)), k[0], k % 4));
        bus.trans_ready_i = 1'b1;
        for (int cyc = 0; cyc < 200 && n_done < 5; cyc++) begin
            #1;
            if (bus.req_ready_o != '0) begin
                checks++;
                if (exp_q.size() == 0 || bus.req_ready_o !== (4'b0001 << exp_q[0].id)) begin
                    errors++;
                    $display("FAIL rr_grant: got %b at grant %0d", bus.req_ready_o, n_grant);
                end
                n_grant++;
            end
            if (bus.trans_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rr_desc: unexpected descriptor %h", cur());
                end else begin
                    e = exp_q.pop_front();
                    if (cur() !== e) begin
                        errors++;
                        $display("FAIL rr_desc: got %h want %h", cur(), e);
                    end
                end
                dcnt = 3;
                did  = int'(bus.trans_id_o);
            end
            if (bus.done_valid_i) n_done++;
            @(negedge clk_i);
            if (n_grant == 5) bus.req_valid_i = '0;
            bus.done_valid_i = (dcnt == 1);
            bus.done_id_i    = 2'(did);
            if (dcnt > 0) dcnt--;
        end
        bus.trans_ready_i = 1'b0;
        bus.done_valid_i  = 1'b0;
        #1;
        checks++;
        if (n_done != 5 || n_grant != 5 || exp_q.size() != 0 || bus.idle_o !== 1'b1 || bus.busy_vec_o !== 4'b0) begin
            errors++;
            $display("FAIL rr_complete: grants=%0d dones=%0d left=%0d idle=%b busy=%b want 5 5 0 1 0000",
                     n_grant, n_done, exp_q.size(), bus.idle_o, bus.busy_vec_o);
        end
    endtask

    task automatic test_recovery();
        int gap = 0;
        do_reset();
        bus.cfg_t_read_write_recovery_i = 32'd5;
        @(negedge clk_i);
        drive_req(1, 32'h3000, 16'd128, 1'b0);
        exp_q.push_back(mk(32'h3000, 16'd128, 1'b0, 1));
        exp_q.push_back(mk(32'h3000, 16'd128, 1'b0, 1));
        @(negedge clk_i);
        #1;
        checks++;
        if (!bus.trans_valid_o) begin
            errors++;
            $display("FAIL recov_issue: tvalid=%b want 1", bus.trans_valid_o);
        end else begin
            e = exp_q.pop_front();
            if (cur() !== e) begin
                errors++;
                $display("FAIL recov_issue: got %h want %h", cur(), e);
            end
        end
        bus.trans_ready_i = 1'b1;
        @(negedge clk_i);
        bus.trans_ready_i = 1'b0;
        bus.done_valid_i  = 1'b1;
        bus.done_id_i     = 2'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            bus.done_valid_i = 1'b0;
            bus.cfg_t_read_write_recovery_i = '0;
            #1;
            if (bus.req_ready_o != '0) break;
            gap++;
        end
        checks++;
        if (gap != 5 || bus.req_ready_o !== 4'b0010) begin
            errors++;
            $display("FAIL recov_gap: gap=%0d ready=%b want 5 0010", gap, bus.req_ready_o);
        end
        @(negedge clk_i);
        bus.req_valid_i = '0;
        #1;
        checks++;
        if (!bus.trans_valid_o) begin
            errors++;
            $display("FAIL recov_second: tvalid=%b want 1", bus.trans_valid_o);
        end else begin
            e = exp_q.pop_front();
            if (cur() !== e) begin
                errors++;
                $display("FAIL recov_second: got %h want %h", cur(), e);
            end
        end
        bus.trans_ready_i = 1'b1;
        @(negedge clk_i);
        bus.trans_ready_i = 1'b0;
        bus.done_valid_i  = 1'b1;
        @(negedge clk_i);
        bus.done_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.idle_o !== 1'b1 || bus.busy_vec_o !== 4'b0) begin
            errors++;
            $display("FAIL recov_zero: idle=%b busy=%b want 1 0000", bus.idle_o, bus.busy_vec_o);
        end
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk_i);
        drive_req(0, 32'h4000, 16'd256, 1'b1);
        drive_req(3, 32'h5000, 16'd32, 1'b0);
        exp_q.push_back(mk(32'h4000, 16'd256, 1'b1, 0));
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL stall_grant: got %b want 0001", bus.req_ready_o);
        end
        @(negedge clk_i);
        bus.req_valid_i = 4'b1000;
        #1;
        e = exp_q.pop_front();
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) begin
                @(negedge clk_i);
                #1;
            end
            checks++;
            if (bus.trans_valid_o !== 1'b1 || cur() !== e || bus.req_ready_o !== 4'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d tvalid=%b desc=%h ready=%b want 1 %h 0000",
                         i, bus.trans_valid_o, cur(), bus.req_ready_o, e);
            end
        end
        bus.trans_ready_i = 1'b1;
        @(negedge clk_i);
        bus.trans_ready_i = 1'b0;
        #1;
        checks++;
        if (bus.trans_valid_o !== 1'b0 || bus.busy_vec_o !== 4'b0001) begin
            errors++;
            $display("FAIL stall_accept: tvalid=%b busy=%b want 0 0001", bus.trans_valid_o, bus.busy_vec_o);
        end
        bus.req_valid_i  = '0;
        bus.done_valid_i = 1'b1;
        bus.done_id_i    = 2'd0;
        @(negedge clk_i);
        bus.done_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.idle_o !== 1'b1 || bus.busy_vec_o !== 4'b0) begin
            errors++;
            $display("FAIL stall_done: idle=%b busy=%b want 1 0000", bus.idle_o, bus.busy_vec_o);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        @(negedge clk_i);
        drive_req(3, 32'h6000, 16'd512, 1'b1);
        exp_q.push_back(mk(32'h6000, 16'd512, 1'b1, 3));
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b1000) begin
            errors++;
            $display("FAIL mism_grant: got %b want 1000", bus.req_ready_o);
        end
        @(negedge clk_i);
        bus.req_valid_i = '0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (!bus.trans_valid_o || cur() !== e) begin
            errors++;
            $display("FAIL mism_desc: tvalid=%b got %h want %h", bus.trans_valid_o, cur(), e);
        end
        bus.trans_ready_i = 1'b1;
        @(negedge clk_i);
        bus.trans_ready_i = 1'b0;
        bus.done_valid_i  = 1'b1;
        bus.done_id_i     = 2'd1;
        @(negedge clk_i);
        bus.done_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.busy_vec_o !== 4'b1000 || bus.idle_o !== 1'b0) begin
            errors++;
            $display("FAIL mism_ignored: busy=%b idle=%b want 1000 0", bus.busy_vec_o, bus.idle_o);
        end
        bus.done_valid_i = 1'b1;
        bus.done_id_i    = 2'd3;
        @(negedge clk_i);
        bus.done_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.busy_vec_o !== 4'b0 || bus.idle_o !== 1'b1) begin
            errors++;
            $display("FAIL mism_match: busy=%b idle=%b want 0000 1", bus.busy_vec_o, bus.idle_o);
        end
    endtask

    task automatic test_done_with_req();
        do_reset();
        @(negedge clk_i);
        drive_req(1, 32'h7000, 16'd4, 1'b0);
        exp_q.push_back(mk(32'h7000, 16'd4, 1'b0, 1));
        exp_q.push_back(mk(32'h7000, 16'd4, 1'b0, 1));
        @(negedge clk_i);
        bus.req_valid_i = '0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (!bus.trans_valid_o || cur() !== e) begin
            errors++;
            $display("FAIL dwr_first: tvalid=%b got %h want %h", bus.trans_valid_o, cur(), e);
        end
        bus.trans_ready_i = 1'b1;
        @(negedge clk_i);
        bus.trans_ready_i = 1'b0;
        bus.done_valid_i  = 1'b1;
        bus.done_id_i     = 2'd1;
        bus.req_valid_i   = 4'b0010;
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0) begin
            errors++;
            $display("FAIL dwr_wait: ready=%b want 0000", bus.req_ready_o);
        end
        @(negedge clk_i);
        bus.done_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0010) begin
            errors++;
            $display("FAIL dwr_regrant: ready=%b want 0010", bus.req_ready_o);
        end
        @(negedge clk_i);
        bus.req_valid_i = '0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (!bus.trans_valid_o || cur() !== e) begin
            errors++;
            $display("FAIL dwr_second: tvalid=%b got %h want %h", bus.trans_valid_o, cur(), e);
        end
        bus.trans_ready_i = 1'b1;
        @(negedge clk_i);
        bus.trans_ready_i = 1'b0;
        bus.done_valid_i  = 1'b1;
        @(negedge clk_i);
        bus.done_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.idle_o !== 1'b1 || bus.busy_vec_o !== 4'b0) begin
            errors++;
            $display("FAIL dwr_end: idle=%b busy=%b want 1 0000", bus.idle_o, bus.busy_vec_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk_i);
        drive_req(2, 32'h8000, 16'd1024, 1'b1);
        exp_q.push_back(mk(32'h8000, 16'd1024, 1'b1, 2));
        @(negedge clk_i);
        bus.req_valid_i = '0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (!bus.trans_valid_o || cur() !== e) begin
            errors++;
            $display("FAIL rmid_desc: tvalid=%b got %h want %h", bus.trans_valid_o, cur(), e);
        end
        bus.trans_ready_i = 1'b1;
        @(negedge clk_i);
        bus.trans_ready_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if (bus.busy_vec_o !== 4'b0 || bus.idle_o !== 1'b1 || cur() !== desc_t'(0)) begin
            errors++;
            $display("FAIL rmid_reset: busy=%b idle=%b desc=%h want 0000 1 0", bus.busy_vec_o, bus.idle_o, cur());
        end
        bus.done_valid_i = 1'b1;
        bus.done_id_i    = 2'd2;
        @(negedge clk_i);
        bus.done_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.busy_vec_o !== 4'b0 || bus.idle_o !== 1'b1 || bus.trans_valid_o !== 1'b0 || bus.req_ready_o !== 4'b0) begin
            errors++;
            $display("FAIL rmid_stray: busy=%b idle=%b tvalid=%b ready=%b want 0000 1 0 0000",
                     bus.busy_vec_o, bus.idle_o, bus.trans_valid_o, bus.req_ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_recovery();
        test_stall();
        test_mismatch();
        test_done_with_req();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
